// File: rtl/pe_vector_mac.sv
// pe_vector_mac: multi-lane MAC with adder tree, seeded accumulation and valid/ready on both sides (optional SATURATE_EN clamps accumulation)
module pe_vector_mac #(
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32,
  parameter int LANES    = 4,
  parameter int SIGNED   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          acc_len,
  input  logic [ACC_W-1:0]          in_psum,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*WEIGHT_W-1:0] activation,
  input  logic [LANES*WEIGHT_W-1:0] weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_psum,
  output logic                      busy,
  output logic                      sat_flag
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [LANES*WEIGHT_W-1:0] act_q, act_d, wgt_q, wgt_d;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [ACC_W-1:0] sum_q, sum_d, acc_q, acc_d, psum_q, psum_d, acc_nxt;
  logic sat_q, sat_d, ovf, hs;

  function automatic logic [ACC_W-1:0] lane_prod(input logic [WEIGHT_W-1:0] a, input logic [WEIGHT_W-1:0] w);
    logic signed [WEIGHT_W:0] ax, wx;
    logic signed [2*WEIGHT_W+1:0] p;
    ax = {SIGNED != 0 && a[WEIGHT_W-1], a};
    wx = {SIGNED != 0 && w[WEIGHT_W-1], w};
    p = (2*WEIGHT_W+2)'(ax) * (2*WEIGHT_W+2)'(wx);
    return ACC_W'(p);
  endfunction

  // stage 2: lane products extended to ACC_W and summed
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++)
      sum_d = sum_d + lane_prod(act_q[i*WEIGHT_W +: WEIGHT_W], wgt_q[i*WEIGHT_W +: WEIGHT_W]);
  end

`ifdef SATURATE_EN
  logic [ACC_W:0] ext;
  // one-bit-wider add exposes overflow; clamp to the representable limit
  always_comb begin
    ext = SIGNED != 0 ? {acc_q[ACC_W-1], acc_q} + {sum_q[ACC_W-1], sum_q} : {1'b0, acc_q} + {1'b0, sum_q};
    ovf = SIGNED != 0 ? ext[ACC_W] ^ ext[ACC_W-1] : ext[ACC_W];
    acc_nxt = !ovf ? ext[ACC_W-1:0] :
              SIGNED == 0 ? '1 :
              ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign ovf = 1'b0;
  assign acc_nxt = acc_q + sum_q;
`endif

  // FSM next state, operand capture, pipeline valids and accumulator update
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    psum_d = psum_q;
    sat_d = sat_q;
    in_ready = state_q == ACCUM && cnt_q < len_q;
    hs = in_valid && in_ready;
    act_d = hs ? activation : act_q;
    wgt_d = hs ? weight : wgt_q;
    s1_v_d = hs;
    s2_v_d = s1_v_q;
    if (s2_v_q) begin
      acc_d = acc_nxt;
      sat_d = sat_q | ovf;
    end
    case (state_q)
      IDLE: if (start) begin
        len_d = acc_len == '0 ? CNT_W'(1) : acc_len;
        acc_d = in_psum;
        cnt_d = '0;
        sat_d = 1'b0;
        state_d = ACCUM;
      end
      ACCUM: if (hs) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == len_q) state_d = DRAIN;
      end
      DRAIN: if (!s1_v_q && !s2_v_q) begin
        psum_d = acc_q;
        state_d = OUTPUT;
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      act_q <= '0;
      wgt_q <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      sum_q <= '0;
      acc_q <= '0;
      psum_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      wgt_q <= wgt_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      sum_q <= sum_d;
      acc_q <= acc_d;
      psum_q <= psum_d;
      sat_q <= sat_d;
    end
  end

  assign out_valid = state_q == OUTPUT;
  assign busy = state_q != IDLE;
  assign out_psum = psum_q;
  assign sat_flag = sat_q;
endmodule

// File: tb/tb_pe_vector_mac.sv
// tb_pe_vector_mac: table-driven and directed checks of pe_vector_mac (SIGNED=1, LANES=4, ACC_W=18)
module tb_pe_vector_mac;
  localparam int W = 8, AW = 18, L = 4, CW = 16;
  logic clk, rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, sat_flag;
  logic [CW-1:0] acc_len;
  logic [AW-1:0] in_psum, out_psum;
  logic [L*W-1:0] activation, weight;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [CW-1:0] len;
    logic [AW-1:0] ps;
    logic [1:0] nb;
    logic [2:0][31:0] a;
    logic [2:0][31:0] w;
    logic [AW-1:0] exp;
    logic sat;
  } vec_t;
  vec_t tbl[5];

  pe_vector_mac #(.WEIGHT_W(W), .ACC_W(AW), .LANES(L), .SIGNED(1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_len(acc_len), .in_psum(in_psum),
    .in_valid(in_valid), .in_ready(in_ready), .activation(activation), .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .busy(busy), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic start_job(input logic [CW-1:0] len, input logic [AW-1:0] ps);
    start = 1'b1;
    acc_len = len;
    in_psum = ps;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] w);
    int t = 0;
    activation = a;
    weight = w;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("beat_accepted", t < 50, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int k;
    start_job(v.len, v.ps);
    for (int b = 0; b < int'(v.nb); b++) send(v.a[b], v.w[b]);
    chk({nm, "_ready_low"}, in_ready, 0);
    wait_out(k);
    chk({nm, "_latency"}, k, 3);
    chk({nm, "_psum"}, out_psum, v.exp);
    chk({nm, "_sat"}, sat_flag, v.sat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    int k;
    logic seen;
    tbl[0] = '{16'd2, 18'd10, 2'd2, {32'h0, pk(1, -1, 2, -2), pk(3, 3, 3, 3)}, {32'h0, pk(5, 5, 5, 5), pk(2, 2, 2, 2)}, 18'd34, 1'b0};
    tbl[1] = '{16'd0, 18'd0, 2'd1, {64'h0, pk(-128, -128, -128, -128)}, {64'h0, pk(-128, -128, -128, -128)}, 18'd65536, 1'b0};
`ifdef SATURATE_EN
    tbl[2] = '{16'd1, 18'd131000, 2'd1, {64'h0, pk(127, 127, 127, 127)}, {64'h0, pk(127, 127, 127, 127)}, 18'd131071, 1'b1};
`else
    tbl[2] = '{16'd1, 18'd131000, 2'd1, {64'h0, pk(127, 127, 127, 127)}, {64'h0, pk(127, 127, 127, 127)}, AW'(-66628), 1'b0};
`endif
    tbl[3] = '{16'd3, AW'(-5), 2'd3, {pk(1, 2, 3, 4), pk(1, 2, 3, 4), pk(1, 2, 3, 4)}, {pk(-1, -1, -1, -1), pk(-1, -1, -1, -1), pk(-1, -1, -1, -1)}, AW'(-35), 1'b0};
    tbl[4] = '{16'd1, 18'd7, 2'd1, {64'h0, pk(10, 20, 30, 40)}, {64'h0, pk(1, 2, 3, 4)}, 18'd307, 1'b0};
    rst_n = 1'b0;
    start = 1'b0;
    acc_len = '0;
    in_psum = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    activation = '0;
    weight = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_psum", out_psum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    // gapped operand beats with extra pulses after the job is full
    start_job(16'd3, 18'd100);
    foreach (tbl[i]) ;
    for (int j = 0; j < 6; j++) begin
      activation = pk(1, 1, 1, 1);
      weight = pk(1, 1, 1, 1);
      in_valid = (j == 0 || j == 3 || j == 5);
      @(negedge clk);
    end
    chk("gap_ready_low", in_ready, 0);
    activation = pk(50, 50, 50, 50);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_out(k);
    chk("gap_psum", out_psum, 112);
    // backpressure in OUTPUT, start ignored, including on the handshake cycle
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start_job(16'd1, 18'd5);
    send(pk(2, 2, 2, 2), pk(3, 3, 3, 3));
    wait_out(k);
    for (int j = 0; j < 5; j++) begin
      start = (j == 2);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_psum", out_psum, 29);
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    chk("bp_done_valid", out_valid, 0);
    chk("bp_done_busy", busy, 0);
    chk("bp_hold_psum", out_psum, 29);
    @(negedge clk);
    chk("bp_start_ignored", busy, 0);
    // asynchronous reset mid-job
    start_job(16'd4, 18'd9);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_psum", out_psum, 0);
    chk("arst_sat", sat_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | out_valid | busy;
    end
    chk("arst_no_result", seen, 0);
    run_vec(tbl[4], "after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
